// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle between the EXE/WB latch, the load-response path and the register file.
// CONFLICT_CNT is present only when WB_ARB_PERF_EN is defined.
interface wb_port_arbiter_if #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  EXE_WE;
    logic [REG_ADDR_W-1:0] EXE_ADDR;
    logic [DATA_W-1:0]     EXE_DATA;
    logic                  MEM_RESP_VALID;
    logic [REG_ADDR_W-1:0] MEM_RESP_ADDR;
    logic [DATA_W-1:0]     MEM_RESP_DATA;
    logic                  LOCK_EXE;
    logic                  RF_WE;
    logic [REG_ADDR_W-1:0] RF_ADDR;
    logic [DATA_W-1:0]     RF_DATA;
    logic [1:0]            FIFO_CNT;
    logic                  MEM_PENDING;
`ifdef WB_ARB_PERF_EN
    logic [31:0]           CONFLICT_CNT;
`endif

    modport slave (
        input  EXE_WE, EXE_ADDR, EXE_DATA,
        input  MEM_RESP_VALID, MEM_RESP_ADDR, MEM_RESP_DATA,
        output LOCK_EXE, RF_WE, RF_ADDR, RF_DATA, FIFO_CNT, MEM_PENDING
`ifdef WB_ARB_PERF_EN
        , output CONFLICT_CNT
`endif
    );

    modport master (
        output EXE_WE, EXE_ADDR, EXE_DATA,
        output MEM_RESP_VALID, MEM_RESP_ADDR, MEM_RESP_DATA,
        input  LOCK_EXE, RF_WE, RF_ADDR, RF_DATA, FIFO_CNT, MEM_PENDING
`ifdef WB_ARB_PERF_EN
        , input CONFLICT_CNT
`endif
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between EXE/WB writes and buffered load responses.
// Optional macro WB_ARB_PERF_EN adds a saturating CONFLICT_CNT of cycles the EXE write was locked.
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic             CLK,
    input  logic             RST,
    wb_port_arbiter_if.slave bus
);
    localparam int unsigned ENT_W    = REG_ADDR_W + DATA_W;
    localparam int unsigned STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [ENT_W-1:0]      r_fifo [2];
    logic [1:0]            r_fifo_cnt;
    logic [STARVE_W-1:0]   r_starve;
    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0]     r_rf_data;

    logic                  w_exe_req;
    logic                  w_mem_in;
    logic                  w_fifo_nonempty;
    logic                  w_force_mem;
    logic                  w_exe_gnt;
    logic                  w_mem_gnt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_wr_idx;
    logic                  w_lock;
    logic [ENT_W-1:0]      w_in_entry;
    logic [ENT_W-1:0]      w_mem_entry;

    // Request qualification, grant priority and FIFO control
    always_comb begin
        w_exe_req       = bus.EXE_WE & (bus.EXE_ADDR != '0);
        w_mem_in        = bus.MEM_RESP_VALID & (bus.MEM_RESP_ADDR != '0);
        w_fifo_nonempty = (r_fifo_cnt != 2'd0);
        w_in_entry      = {bus.MEM_RESP_ADDR, bus.MEM_RESP_DATA};
        w_mem_entry     = w_fifo_nonempty ? r_fifo[0] : w_in_entry;
        w_force_mem     = (r_fifo_cnt == 2'd2) | (w_fifo_nonempty & (r_starve == STARVE_LIM));
        w_exe_gnt       = w_exe_req & ~w_force_mem;
        w_mem_gnt       = ~w_exe_gnt & (w_fifo_nonempty | w_mem_in);
        w_pop           = w_mem_gnt & w_fifo_nonempty;
        // A bypassed response is written directly and never occupies a slot
        w_push          = w_mem_in & ~(w_mem_gnt & ~w_fifo_nonempty);
        w_wr_idx        = (r_fifo_cnt == 2'd2) | ((r_fifo_cnt == 2'd1) & ~w_pop);
        w_lock          = RST & w_exe_req & ~w_exe_gnt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_fifo_cnt <= 2'd0;
            r_starve   <= '0;
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_data  <= '0;
        end else begin
            // Shift on pop first so a simultaneous push lands behind the new head
            if (w_pop) begin
                r_fifo[0] <= r_fifo[1];
            end
            if (w_push) begin
                r_fifo[w_wr_idx] <= w_in_entry;
            end
            r_fifo_cnt <= r_fifo_cnt + 2'(w_push) - 2'(w_pop);

            if (w_mem_gnt || !w_fifo_nonempty) begin
                r_starve <= '0;
            end else if (r_starve != STARVE_LIM) begin
                r_starve <= r_starve + STARVE_W'(1);
            end

            r_rf_we <= w_exe_gnt | w_mem_gnt;
            if (w_exe_gnt) begin
                r_rf_addr <= bus.EXE_ADDR;
                r_rf_data <= bus.EXE_DATA;
            end else if (w_mem_gnt) begin
                r_rf_addr <= w_mem_entry[ENT_W-1 -: REG_ADDR_W];
                r_rf_data <= w_mem_entry[DATA_W-1:0];
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;

    // Cycles the EXE write was held off, saturating
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_conflict_cnt <= '0;
        end else if (w_lock && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign bus.CONFLICT_CNT = r_conflict_cnt;
`endif

    assign bus.LOCK_EXE    = w_lock;
    assign bus.RF_WE       = r_rf_we;
    assign bus.RF_ADDR     = r_rf_addr;
    assign bus.RF_DATA     = r_rf_data;
    assign bus.FIFO_CNT    = r_fifo_cnt;
    assign bus.MEM_PENDING = (r_fifo_cnt != 2'd0);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios then random traffic against a queue-based reference model.
module tb_wb_port_arbiter;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;
    localparam int unsigned SM = 3;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    wb_port_arbiter_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus();

    wb_port_arbiter #(.DATA_W(DW), .REG_ADDR_W(AW), .STARVE_MAX(SM)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    int            checks = 0;
    int            errors = 0;
    ent_t          q[$];
    int            starve;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [31:0]   exp_conf;
    bit            last_lock;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        starve    = 0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_conf  = '0;
        last_lock = 1'b0;
    endtask

    task automatic check_outputs();
        chk_eq("rf_we",       64'(bus.RF_WE), 64'(exp_we));
        chk_eq("rf_addr",     64'(bus.RF_ADDR), 64'(exp_addr));
        chk_eq("rf_data",     bus.RF_DATA, exp_data);
        chk_eq("fifo_cnt",    64'(bus.FIFO_CNT), 64'(q.size()));
        chk_eq("mem_pending", 64'(bus.MEM_PENDING), 64'(q.size() != 0));
        chk_eq("fifo_le2",    64'(bus.FIFO_CNT <= 2'd2), 64'd1);
`ifdef WB_ARB_PERF_EN
        chk_eq("conflict_cnt", 64'(bus.CONFLICT_CNT), 64'(exp_conf));
`endif
    endtask

    // One cycle: check prior results, drive, check lock, advance model
    task automatic step(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        bit   exe_req, mem_in, force_m, lock;
        int   src;
        int   qs;
        ent_t e;
        ent_t inc;
        @(negedge CLK);
        check_outputs();
        bus.EXE_WE         = we;
        bus.EXE_ADDR       = a;
        bus.EXE_DATA       = d;
        bus.MEM_RESP_VALID = mv;
        bus.MEM_RESP_ADDR  = ma;
        bus.MEM_RESP_DATA  = md;
        #1;
        exe_req = we && (a != 0);
        mem_in  = mv && (ma != 0);
        qs      = q.size();
        force_m = (qs == 2) || (qs > 0 && starve == int'(SM));
        if (force_m)                     src = 2;
        else if (exe_req)                src = 1;
        else if (qs > 0 || mem_in)       src = 2;
        else                             src = 0;
        lock = exe_req && (src != 1);
        chk_eq("lock_exe", 64'(bus.LOCK_EXE), 64'(lock));
        inc.a = ma;
        inc.d = md;
        exp_we = (src != 0);
        if (src == 1) begin
            exp_addr = a;
            exp_data = d;
            if (mem_in) q.push_back(inc);
        end else if (src == 2) begin
            if (qs > 0) begin
                e = q.pop_front();
                exp_addr = e.a;
                exp_data = e.d;
                if (mem_in) q.push_back(inc);
            end else begin
                exp_addr = ma;
                exp_data = md;
            end
        end
        if (qs == 0 || src == 2) starve = 0;
        else if (starve < int'(SM)) starve = starve + 1;
        if (lock && exp_conf != 32'hFFFF_FFFF) exp_conf = exp_conf + 32'd1;
        last_lock = lock;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic          rwe;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic          rmv;
        logic [AW-1:0] rma;
        logic [DW-1:0] rmd;

        RST = 1'b0;
        bus.EXE_WE = 1'b0;         bus.EXE_ADDR = '0;      bus.EXE_DATA = '0;
        bus.MEM_RESP_VALID = 1'b0; bus.MEM_RESP_ADDR = '0; bus.MEM_RESP_DATA = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        chk_eq("rst_lock", 64'(bus.LOCK_EXE), 64'd0);
        check_outputs();
        RST = 1'b1;

        // Plain EXE write, then a bypassed load
        step(1'b1, 5'd7, 64'h11, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd3, 64'hAA);
        idle(2);

        // EXE stream with two loads: FIFO fills, head is forced out
        step(1'b1, 5'd5, 64'h55, 1'b1, 5'd8, 64'h88);
        step(1'b1, 5'd5, 64'h56, 1'b1, 5'd9, 64'h99);
        for (int i = 0; i < 4; i++) step(1'b1, 5'd5, 64'h57, 1'b0, '0, '0);
        idle(4);

        // One buffered load starved by continuous EXE writes
        step(1'b1, 5'd6, 64'h60, 1'b1, 5'd12, 64'hC0);
        for (int i = 0; i < 6; i++) step(1'b1, 5'd6, 64'(61 + i), 1'b0, '0, '0);
        idle(3);

        // x0 writes from both sources are dropped
        step(1'b1, 5'd0, 64'hDEAD, 1'b1, 5'd0, 64'hBEEF);
        step(1'b1, 5'd0, 64'hDEAD, 1'b1, 5'd0, 64'hBEEF);
        idle(2);

        // Async reset mid-burst with a full FIFO
        step(1'b1, 5'd5, 64'h70, 1'b1, 5'd8, 64'h71);
        step(1'b1, 5'd5, 64'h70, 1'b1, 5'd9, 64'h72);
        @(negedge CLK);
        check_outputs();
        chk_eq("burst_full", 64'(bus.FIFO_CNT), 64'd2);
        bus.EXE_WE = 1'b1; bus.EXE_ADDR = 5'd5;
        bus.MEM_RESP_VALID = 1'b1; bus.MEM_RESP_ADDR = 5'd10;
        #2;
        RST = 1'b0;
        #1;
        chk_eq("arst_fifo_cnt", 64'(bus.FIFO_CNT), 64'd0);
        chk_eq("arst_rf_we",    64'(bus.RF_WE), 64'd0);
        chk_eq("arst_lock",     64'(bus.LOCK_EXE), 64'd0);
`ifdef WB_ARB_PERF_EN
        chk_eq("arst_conflict", 64'(bus.CONFLICT_CNT), 64'd0);
`endif
        @(negedge CLK);
        bus.EXE_WE = 1'b0; bus.MEM_RESP_VALID = 1'b0;
        model_reset();
        @(negedge CLK);
        RST = 1'b1;

        // Random traffic; a locked EXE request is re-presented unchanged
        rwe = 1'b0; ra = '0; rd = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!last_lock) begin
                rwe = ($urandom_range(0, 9) < 7);
                ra  = AW'($urandom_range(0, 31));
                rd  = {$urandom, $urandom};
            end
            rmv = ($urandom_range(0, 9) < 4);
            rma = AW'($urandom_range(0, 31));
            rmd = {$urandom, $urandom};
            step(rwe, ra, rd, rmv, rma, rmd);
        end
        idle(4);
        @(negedge CLK);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
